apb_slave_regfile: RTL and testbench

//  APB3 completer (slave) on the far side of ahb_to_apb_bridge: a bank of NUM_REGS 32-bit R/W

---
 rtl/apb_slave_regfile.sv | 146 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// APB3 completer: NUM_REGS word-spaced R/W registers with a fixed wait-state count
// and address-miss handling. Optional macro APB_SLV_ERR_EN makes misses complete
// with PSLVERR=1; without it PSLVERR stays 0 and misses complete silently.
module apb_slave_regfile #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       NUM_REGS    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       WAIT_STATES = 0
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

`ifdef APB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               write_q, write_d;
    logic               hit_q, hit_d;
    logic [DATA_W-1:0]  prdata_q, prdata_d;
    logic               pready_q, pready_d;
    logic               pslverr_q, pslverr_d;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];

    logic [ADDR_W-1:0]  offset_c;
    logic               hit_c;
    logic [IDX_W-1:0]   idx_c;
    logic               commit_c;

    // Live address decode, only consumed at the setup edge
    assign offset_c = PADDR - BASE_ADDR;
    assign hit_c    = (PADDR >= BASE_ADDR) && (PADDR[1:0] == 2'b00) &&
                      ((offset_c >> 2) < ADDR_W'(NUM_REGS));
    assign idx_c    = IDX_W'(offset_c >> 2);

    // Write commits on the edge leaving DONE while the requester still holds the access phase
    assign commit_c = (state_q == S_DONE) && PSEL && PENABLE && write_q && hit_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        hit_d     = hit_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    idx_d   = idx_c;
                    write_d = PWRITE;
                    hit_d   = hit_c;
                    cnt_d   = WAIT_CNT;
                    state_d = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // DONE lasts one cycle, so state_d==DONE only on the entering edge
        if (state_d == S_DONE) begin
            pready_d  = 1'b1;
            pslverr_d = ERR_EN && !hit_d;
            if (!write_d) begin
                prdata_d = hit_d ? regs_q[idx_d] : '0;
            end
        end
    end

    // Control and response registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            hit_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            hit_q     <= hit_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Register bank
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit_c) begin
            regs_q[idx_q] <= PWDATA;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: one instance with 0 wait states, one with 2,
// checked against an array model of the register bank.
module tb_apb_slave_regfile;

    localparam int NREG = 16;

    logic        clk;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata_w  [2];
    logic        pready_w  [2];
    logic        pslverr_w [2];
    logic [NREG*32-1:0] regs_w [2];

    logic [31:0] model [2][NREG];
    logic [31:0] exp_prdata [2];
    int checks = 0;
    int errors = 0;

    apb_slave_regfile #(.WAIT_STATES(0)) u0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata_w[0]), .PREADY(pready_w[0]), .PSLVERR(pslverr_w[0]),
        .regs_o(regs_w[0])
    );

    apb_slave_regfile #(.WAIT_STATES(2)) u1 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata_w[1]), .PREADY(pready_w[1]), .PSLVERR(pslverr_w[1]),
        .regs_o(regs_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic int wait_states(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic bit is_hit(input logic [31:0] addr);
        return (addr % 4 == 0) && (addr / 4 < NREG);
    endfunction

    function automatic logic [31:0] reg_of(input int d, input int i);
        return regs_w[d][i*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input int d, input string tag);
        for (int i = 0; i < NREG; i++) begin
            chk(tag, reg_of(d, i), model[d][i]);
        end
    endtask

    task automatic bus_idle(input int d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        pwrite[d]  = 1'b0;
        paddr[d]   = '0;
        pwdata[d]  = '0;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            exp_prdata[d] = '0;
            for (int i = 0; i < NREG; i++) model[d][i] = '0;
        end
    endtask

    // One complete transfer with latency, response and register-bank checks
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        bit hit;
        bit done;
        int n;
        logic exp_err;
        hit = is_hit(addr);
`ifdef APB_SLV_ERR_EN
        exp_err = !hit;
`else
        exp_err = 1'b0;
`endif
        @(posedge clk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr;
        pwdata[d] = $urandom;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        pwdata[d]  = wdata;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            n++;
            @(negedge clk);
            if (pready_w[d]) begin
                done = 1'b1;
            end else begin
                chk("slverr_without_ready", 32'(pslverr_w[d]), 32'd0);
                if (wr && hit) chk("reg_before_commit", reg_of(d, addr / 4), model[d][addr / 4]);
                @(posedge clk); #1;
            end
        end
        chk("ready_latency", 32'(n), 32'(wait_states(d) + 1));
        if (done) begin
            chk("pslverr", 32'(pslverr_w[d]), 32'(exp_err));
            if (!wr) begin
                if (hit) exp_prdata[d] = model[d][addr / 4];
                else     exp_prdata[d] = '0;
                chk("prdata", prdata_w[d], exp_prdata[d]);
            end
        end
        @(posedge clk); #1;
        bus_idle(d);
        if (wr && hit) model[d][addr / 4] = wdata;
        @(negedge clk);
        chk("ready_one_cycle", 32'(pready_w[d]), 32'd0);
        chk("prdata_hold", prdata_w[d], exp_prdata[d]);
        chk_regs(d, "regs_after");
    endtask

    initial begin
        logic [31:0] a;
        int d;
        int r;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) bus_idle(i);
        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_pready", 32'(pready_w[i]), 32'd0);
            chk("reset_pslverr", 32'(pslverr_w[i]), 32'd0);
            chk("reset_prdata", prdata_w[i], 32'd0);
            chk_regs(i, "reset_regs");
        end
        rst_n = 1'b1;

        // Single write / readback, then a run of sequential addresses
        xfer(0, 1'b1, 32'h10, 32'hA5A5A5A5);
        chk("reg4_written", reg_of(0, 4), 32'hA5A5A5A5);
        xfer(0, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 4; i++) xfer(0, 1'b1, 32'h14 + 32'(4 * i), 32'h1000_0000 + 32'(i * 3 + 7));
        for (int i = 0; i < 4; i++) xfer(0, 1'b0, 32'h14 + 32'(4 * i), 32'h0);

        // Wait-state instance
        xfer(1, 1'b1, 32'h08, 32'hDEADBEEF);
        xfer(1, 1'b0, 32'h08, 32'h0);

        // Misses: out of range and misaligned
        for (int i = 0; i < 2; i++) begin
            xfer(i, 1'b1, 32'h100, 32'h12345678);
            xfer(i, 1'b0, 32'h102, 32'h0);
            xfer(i, 1'b1, 32'h0D, 32'hFFFFFFFF);
        end

        // Access phase without a setup phase is ignored
        @(posedge clk); #1;
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h0; pwdata[0] = 32'hBAD0BAD0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_setup_ready", 32'(pready_w[0]), 32'd0);
        end
        @(posedge clk); #1;
        bus_idle(0);
        @(negedge clk);
        chk_regs(0, "no_setup_regs");

        // Aborted transfer: PSEL dropped in access cycle 2
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h04; pwdata[1] = 32'h0;
        @(posedge clk); #1;
        penable[1] = 1'b1; pwdata[1] = 32'hCAFEF00D;
        @(negedge clk);
        chk("abort_ready_c1", 32'(pready_w[1]), 32'd0);
        @(posedge clk); #1;
        bus_idle(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_ready", 32'(pready_w[1]), 32'd0);
        end
        chk_regs(1, "abort_regs");
        xfer(1, 1'b0, 32'h04, 32'h0);
        xfer(1, 1'b1, 32'h04, 32'h0BADCAFE);

        // Reset in the middle of a waited write
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h0C; pwdata[1] = 32'h0;
        @(posedge clk); #1;
        penable[1] = 1'b1; pwdata[1] = 32'h77777777;
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        for (int i = 0; i < 2; i++) begin
            chk("midreset_pready", 32'(pready_w[i]), 32'd0);
            chk("midreset_prdata", prdata_w[i], 32'd0);
            chk_regs(i, "midreset_regs");
        end
        bus_idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 1'b1, 32'h0C, 32'h31415926);
        xfer(1, 1'b0, 32'h0C, 32'h0);

        // Randomized traffic on both instances
        for (int k = 0; k < 200; k++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = 32'(4 * $urandom_range(0, NREG - 1));
            else if (r == 8) a = 32'(4 * $urandom_range(0, NREG - 1) + $urandom_range(1, 3));
            else             a = 32'(4 * NREG) + 32'(4 * $urandom_range(0, 1000));
            xfer(d, 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
